// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle,
// holding the pipeline through stall_o until a registered result is presented with done_o.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] data_rs1,
  input  logic [WIDTH-1:0] data_rs2,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int               CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic               w_s1_signed, w_s2_signed, w_neg1, w_neg2;
  logic               w_div_zero, w_ovf, w_early;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_special;
  logic [WIDTH:0]     w_sum, w_trial;
  logic [2*WIDTH-1:0] w_acc_next, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_final;

  // Signedness: rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM.
  assign w_s1_signed = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign w_s2_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
  assign w_neg1      = w_s1_signed & data_rs1[WIDTH-1];
  assign w_neg2      = w_s2_signed & data_rs2[WIDTH-1];
  assign w_abs1      = w_neg1 ? (~data_rs1 + 1'b1) : data_rs1;
  assign w_abs2      = w_neg2 ? (~data_rs2 + 1'b1) : data_rs2;
  assign w_div_zero  = op_i[2] & (data_rs2 == '0);
  assign w_ovf       = op_i[2] & ~op_i[0] & (data_rs1 == MIN_NEG) & (&data_rs2);
  assign w_early     = EARLY_OUT & (w_div_zero | w_ovf);
  assign w_special   = w_div_zero ? (op_i[1] ? data_rs1 : '1)
                                  : (op_i[1] ? '0 : MIN_NEG);

  // Multiply keeps {product_hi, multiplier} and shifts right; divide keeps {rem, quo} and shifts left.
  always_comb begin
    // NOTE: every output of this block is assigned on all paths (default arm included) so no latch is inferred.
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    if (r_op[2])
      w_acc_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                  : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    w_prod = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
    w_quo  = r_neg_q ? (~w_acc_next[WIDTH-1:0] + 1'b1) : w_acc_next[WIDTH-1:0];
    w_rem  = r_neg_r ? (~w_acc_next[2*WIDTH-1:WIDTH] + 1'b1) : w_acc_next[2*WIDTH-1:WIDTH];
    case (r_op)
      3'b000:                 w_final = w_prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  // The corrected result is registered on the edge into FINISH so it is valid alongside done_o.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush_i) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: if (start_i) begin
            r_op    <= op_i;
            r_a     <= w_abs1;
            r_b     <= w_abs2;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_cnt   <= '0;
            r_acc   <= op_i[2] ? {{WIDTH{1'b0}}, w_abs1} : {{WIDTH{1'b0}}, w_abs2};
            if (w_early) begin
              r_state  <= FINISH;
              r_result <= w_special;
              r_done   <= 1'b1;
            end else begin
              r_state <= CALC;
            end
          end
          CALC: begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_state  <= FINISH;
              r_result <= w_final;
              r_done   <= 1'b1;
            end
          end
          FINISH:  r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o   = (r_state != IDLE);
  assign stall_o  = ((r_state == IDLE) & start_i & ~flush_i) | (r_state == CALC);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: vector table through a result scoreboard, plus reset, flush
// and held-start sequences around the multi-cycle corner cases.
`timescale 1ns/1ps
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] data_rs1 = '0;
  logic [31:0] data_rs2 = '0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t tbl[17];

  muldiv_seq #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .data_rs1(data_rs1), .data_rs2(data_rs2), .flush_i(flush_i),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at a negedge. lat counts edges after the accepting edge.
  task automatic run_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int exp_lat, input bit hold);
    int lat;
    int stalls;
    string tag;
    lat = 0;
    stalls = 0;
    tag = $sformatf("op%0d a=%08h b=%08h", op, a, b);
    start_i = 1'b1; op_i = op; data_rs1 = a; data_rs2 = b;
    exp_q.push_back(res);
    #1 if (stall_o) stalls++;
    @(posedge clk);
    #1;
    if (!hold) start_i = 1'b0;
    op_i = 3'($urandom); data_rs1 = $urandom; data_rs2 = $urandom;
    @(negedge clk);
    while (!done_o && lat < 100) begin
      if (stall_o) stalls++;
      @(posedge clk);
      lat++;
      #1;
      if (hold) begin
        op_i = 3'($urandom); data_rs1 = $urandom; data_rs2 = $urandom;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check({tag, " done"}, 32'(done_o), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat == 0 ? 1 : exp_lat + 1));
    if (exp_q.size() != 0) check({tag, " result"}, result_o, exp_q.pop_front());
    else                   check({tag, " scoreboard depth"}, 32'(exp_q.size()), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done_o), 32'd0);
    check({tag, " result hold"}, result_o, res);
  endtask

  task automatic idle_watch(input int n, input string name);
    int d;
    d = 0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) d++;
    end
    check(name, 32'(d), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    tbl[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32};
    tbl[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32};
    tbl[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32};
    tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32};
    tbl[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
    tbl[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32};
    tbl[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       32};
    tbl[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        32};
    tbl[8]  = '{3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 0};
    tbl[9]  = '{3'b111, 32'h1234,     32'd0,        32'h1234,     0};
    tbl[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    tbl[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
    tbl[12] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32};
    tbl[13] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32};
    tbl[14] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32};
    tbl[15] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32};
    tbl[16] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Leave a nonzero result, then reset in the middle of a divide.
    run_vec(tbl[1].op, tbl[1].a, tbl[1].b, tbl[1].res, tbl[1].lat, 1'b0);
    start_i = 1'b1; op_i = 3'b100; data_rs1 = 32'd100; data_rs2 = 32'd7;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("busy mid-calc", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid-calc reset result", result_o, 32'd0);
    check("mid-calc reset busy", 32'(busy_o), 32'd0);
    check("mid-calc reset done", 32'(done_o), 32'd0);
    check("mid-calc reset stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch(40, "no done after reset abort");

    for (int i = 0; i < 17; i++)
      run_vec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, 1'b0);

    // Flush a divide during cycle T+10.
    dn = 0;
    start_i = 1'b1; op_i = 3'b100; data_rs1 = 32'h7FFFFFFF; data_rs2 = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1 if (done_o) dn++;
    end
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    check("flush busy", 32'(busy_o), 32'd0);
    check("flush done", 32'(done_o), 32'd0);
    check("flush result kept", result_o, tbl[16].res);
    check("flush early done count", 32'(dn), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    run_vec(3'b101, 32'd100, 32'd7, 32'd14, 32, 1'b0);

    // Flush wins over start in the same cycle.
    flush_i = 1'b1; start_i = 1'b1; op_i = 3'b000; data_rs1 = 32'd2; data_rs2 = 32'd3;
    #1 check("flush-vs-start stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1 check("flush-vs-start busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;

    // start_i held high with scrambled operands throughout CALC.
    run_vec(3'b000, 32'd3, 32'd5, 32'd15, 32, 1'b1);
    idle_watch(40, "single done with held start");
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle RV32M multiply/divide sequencer attached beside the execute-stage ALU. It accepts rs1/rs2 operands and a funct3 opcode from decode, runs an iterative one-bit-per-cycle shift-add multiply or restoring divide, and holds the pipeline through stall_o until the result is ready. Writeback muxes result_o in place of the ALU result during the done_o cycle.

Parameters:
WIDTH, 32, operand/result width; only 32 is verified.
EARLY_OUT, 1, when 1, divide-by-zero and signed-overflow cases bypass iteration.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start_i  input  1  request; sampled only in IDLE
op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
data_rs1  input  WIDTH  operand A (multiplicand/dividend)
data_rs2  input  WIDTH  operand B (multiplier/divisor)
flush_i  input  1  abort current operation (branch/trap)
busy_o  output  1  high in CALC and FINISH
stall_o  output  1  pipeline hold request
done_o  output  1  one-cycle pulse, result_o valid
result_o  output  WIDTH  registered result

Behaviour:
- Reset (rst_n low at a clock edge): state to IDLE, counter to 0, all internal registers to 0, result_o=0, done_o=0, busy_o=0. Reset mid-operation discards the operation with no done_o.
- Clock, reset and flush are the only sources of state change; one clock domain.
- States: IDLE, CALC, FINISH.
- IDLE: if start_i=1 and flush_i=0, latch op_i, |rs1|, |rs2| and sign flags, then move to CALC with counter=0. Signedness: MUL/MULH/DIV/REM treat both operands as signed, MULHSU treats rs1 as signed and rs2 as unsigned, MULHU/DIVU/REMU treat both as unsigned.
- IDLE with EARLY_OUT=1: divide-by-zero or signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM) goes straight to FINISH with the special result preloaded.
- CALC: one iteration per cycle for 32 cycles.
  - Multiply: 64-bit accumulator, add-shift on the multiplier LSB.
  - Divide: restoring shift-subtract, 32-bit quotient and remainder.
  - counter==31 moves to FINISH.
- FINISH: apply sign correction.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - Select the result: MUL takes the low word, MULH/MULHSU/MULHU take the high word.
  - Register result_o and drive done_o=1 for this cycle only, then return to IDLE.
- Latency: start accepted at edge T gives CALC for cycles T+1..T+32, with FINISH/done_o at cycle T+33 (33 cycles). Early-out gives done_o at cycle T+1.
- Special results: divide by zero gives DIV/DIVU=0xFFFFFFFF, REM/REMU=rs1. Signed overflow gives DIV=0x80000000, REM=0.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. It is low in FINISH so the stage advances while capturing result_o.
- result_o holds its last value until the next FINISH.
- start_i while in CALC or FINISH is ignored. Decode keeps start_i high only while the instruction is held.
- flush_i=1 in any state: next state is IDLE, no done_o, result_o unchanged. Flush takes priority over start in the same cycle.
- Operand inputs are sampled only at acceptance; later changes have no effect.

Test Plan:
- Reset asserted mid-CALC, then start MUL rs1=7, rs2=0xFFFFFFFD: outputs cleared on the reset edge; after the new start, stall_o is high for 33 cycles, then done_o pulses with result_o=0xFFFFFFEB at T+33.
- MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE. MULH 0x80000000×0x80000000 gives 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 gives 0xFFFFFFFD. REM of the same gives 0xFFFFFFFF. DIVU 100/7 gives 14. REMU 100/7 gives 2.
- DIVU 0x1234/0 gives 0xFFFFFFFF and REMU 0x1234/0 gives 0x1234, both with done_o at T+1. DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0.
- flush_i at cycle T+10 of a DIV: IDLE next cycle, no done_o, result_o keeps its previous value, and a new start is accepted the following cycle.
- start_i held high with changing operands during CALC: no restart, done_o exactly once, result matches the operands latched at acceptance.
